dot_bias_relu_drain: RTL
========================

Name: dot_bias_relu_drain

Overview:
- Downstream stage of the matrix-vector dot-product engine.
- On each new completed product, captures all I results (Q-format, N-bit signed), adds a per-row bias with saturation, and optionally applies ReLU.
- Streams the results one element per cycle over a valid/ready interface to the next layer or writeback.
- Tracks a running argmax and reports it at end of frame.

Parameters:
- I, 20, number of result elements per frame (rows of the product).
- Q, 15, fractional bits. Bias uses the same Q format, so no shift is applied.
- N, 32, data width, two's complement.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active-high (asserted = 1).
- in_C[0:I-1]  input  N each  product vector from the dot engine.
- in_done  input  1  dot engine done level. Stays high while results are valid.
- in_bias[0:I-1]  input  N each  per-row bias, sampled at capture.
- relu_en  input  1  ReLU enable, sampled at capture.
- out_data  output  N  biased/activated element.
- out_idx  output  $clog2(I)  row index of out_data.
- out_valid  output  1  out_data/out_idx/out_last valid.
- out_ready  input  1  downstream accept.
- out_last  output  1  high with element I-1.
- busy  output  1  high in CAPTURE or DRAIN.
- frame_done  output  1  one-cycle pulse after the last handshake.
- max_idx  output  $clog2(I)  argmax of the last completed frame.
- max_val  output  N  value at max_idx.
- overrun  output  1  sticky: an in_done rise was seen while busy.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Internal done_q is 1, so an in_done already high after reset does not start a frame.
- Frame trigger: start = in_done & ~done_q, where done_q is registered in_done every cycle.
- States:
  - IDLE: on start, register in_C, in_bias and relu_en into an I-entry buffer, then go to CAPTURE.
  - CAPTURE: one cycle. Compute the first element, set out_valid=1 and out_idx=0, go to DRAIN.
  - DRAIN: on out_valid & out_ready, advance the index and load the next element the same cycle (back-to-back throughput of 1/cycle). On the handshake of index I-1, clear out_valid, pulse frame_done next cycle, return to IDLE.
- Latency: in_done rises at edge k, out_valid is first high after edge k+2. Minimum frame time is I+2 cycles.
- Hold rule: while out_valid & ~out_ready, out_data, out_idx and out_last are held stable.
- Arithmetic:
  - sum = in_C[i] + in_bias[i] computed at N+1 bits.
  - Saturate to [-2^(N-1), 2^(N-1)-1].
  - If relu_en, negative results become 0.
  - ReLU is applied after saturation.
- Argmax:
  - Signed compare over emitted values only.
  - Ties keep the lower index.
  - Internal tracker resets at frame start.
  - max_idx/max_val update together with the frame_done pulse and hold until the next frame_done.
- start while busy: ignored, and sets overrun. The in-flight frame is unaffected.
- start in the frame_done cycle: the FSM is already in IDLE, so the new frame is accepted.
- Reset mid-frame: immediate abort.
  - out_valid=0 and the buffer is discarded.
  - max_* and overrun are cleared.
  - No frame_done is issued.
- out_ready high with out_valid low has no effect.

Test Plan:
- I=4, in_C={1.0,-0.5,0.25,2.0} (Q15), bias=0, relu_en=0, out_ready=1:
  - Four consecutive beats with idx 0..3, values as given.
  - out_last on idx 3, then frame_done.
  - max_idx=3, max_val=0x00010000.
- Same data, relu_en=1, bias={0,0,-0.5,0}:
  - Outputs {1.0,0,0,2.0}.
  - Ties at 0 do not matter; max_idx=3.
- Saturation, N=32:
  - in_C[0]=0x7FFFFFF0, bias[0]=0x100 gives 0x7FFFFFFF.
  - in_C[1]=0x80000010, bias[1]=-0x100 gives 0x80000000.
- Backpressure: out_ready toggles 1,0,0,1,…
  - out_data/out_idx stable across stalled cycles.
  - No element lost or duplicated.
  - Frame takes I + stall-count + 2 cycles.
- Pulse in_done low then high during DRAIN:
  - overrun=1 and stays 1.
  - The current frame completes with the original data.
  - The held-high in_done after frame_done does not start a frame.
- Assert rst_n at idx 2 of 4:
  - All outputs 0 next sample.
  - With in_done held high across reset, no new frame starts.
  - The next low-to-high in_done starts a normal frame.

Source files
------------

// File: rtl/dot_bias_relu_drain.sv
// Bias/saturate/ReLU stage behind the dot-product engine: captures a finished product vector,
// streams it out one element per cycle over valid/ready and reports the frame's argmax.
module dot_bias_relu_drain #(
    parameter int unsigned I = 20,
    parameter int unsigned Q = 15,
    parameter int unsigned N = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_C [I],
    input  logic                 in_done,
    input  logic [N-1:0]         in_bias [I],
    input  logic                 relu_en,
    output logic [N-1:0]         out_data,
    output logic [$clog2(I)-1:0] out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 frame_done,
    output logic [$clog2(I)-1:0] max_idx,
    output logic [N-1:0]         max_val,
    output logic                 overrun
);

    localparam int unsigned IdxW = $clog2(I);

    // Bias shares the product's fixed-point format, so the add needs no alignment shift.
    if (Q >= N) begin : g_q_check
        $error("Q must be smaller than N");
    end

    typedef enum logic [1:0] {StIdle, StCapture, StDrain} state_e;

    state_e          state_q, state_d;
    logic            done_q;
    logic            start;
    logic [N-1:0]    buf_c_q [I];
    logic [N-1:0]    buf_b_q [I];
    logic            relu_q;
    logic [IdxW-1:0] idx_q, idx_d, elem_idx;
    logic [N-1:0]    data_q, data_d, elem;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            fdone_q, fdone_d;
    logic            overrun_q, overrun_d;
    logic [IdxW-1:0] run_idx_q, run_idx_d, max_idx_q, max_idx_d, cand_idx;
    logic [N-1:0]    run_val_q, run_val_d, max_val_q, max_val_d, cand_val;
    logic            cand_upd, hs, is_last;

    function automatic logic [N-1:0] bias_act(input logic [N-1:0] c, input logic [N-1:0] b,
                                              input logic relu);
        logic [N:0]   sum;
        logic [N-1:0] res;
        sum = {c[N-1], c} + {b[N-1], b};
        if (sum[N] != sum[N-1]) begin
            res = sum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            res = sum[N-1:0];
        end
        if (relu && res[N-1]) begin
            res = '0;
        end
        return res;
    endfunction

    assign start    = in_done & ~done_q;
    assign hs       = valid_q & out_ready;
    assign is_last  = (idx_q == IdxW'(I - 1));
    // Element prepared for the next beat: index 0 in CAPTURE, idx+1 on a DRAIN handshake.
    assign elem_idx = (state_q == StDrain && !is_last) ? idx_q + 1'b1 : '0;
    assign elem     = bias_act(buf_c_q[elem_idx], buf_b_q[elem_idx], relu_q);

    // Strictly greater keeps the lower index on ties; index 0 seeds the tracker.
    assign cand_upd = (idx_q == '0) || ($signed(data_q) > $signed(run_val_q));
    assign cand_idx = cand_upd ? idx_q : run_idx_q;
    assign cand_val = cand_upd ? data_q : run_val_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        fdone_d   = 1'b0;
        overrun_d = overrun_q | (start & (state_q != StIdle));
        run_idx_d = run_idx_q;
        run_val_d = run_val_q;
        max_idx_d = max_idx_q;
        max_val_d = max_val_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StCapture;
                    run_idx_d = '0;
                    run_val_d = '0;
                end
            end
            StCapture: begin
                state_d = StDrain;
                idx_d   = '0;
                data_d  = elem;
                valid_d = 1'b1;
                last_d  = (I == 1);
            end
            StDrain: begin
                if (hs) begin
                    run_idx_d = cand_idx;
                    run_val_d = cand_val;
                    if (is_last) begin
                        state_d   = StIdle;
                        valid_d   = 1'b0;
                        last_d    = 1'b0;
                        fdone_d   = 1'b1;
                        max_idx_d = cand_idx;
                        max_val_d = cand_val;
                    end else begin
                        idx_d  = elem_idx;
                        data_d = elem;
                        last_d = (elem_idx == IdxW'(I - 1));
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= StIdle;
            done_q    <= 1'b1;
            idx_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            fdone_q   <= 1'b0;
            overrun_q <= 1'b0;
            run_idx_q <= '0;
            run_val_q <= '0;
            max_idx_q <= '0;
            max_val_q <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= in_done;
            idx_q     <= idx_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            fdone_q   <= fdone_d;
            overrun_q <= overrun_d;
            run_idx_q <= run_idx_d;
            run_val_q <= run_val_d;
            max_idx_q <= max_idx_d;
            max_val_q <= max_val_d;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int k = 0; k < I; k++) begin
                buf_c_q[k] <= '0;
                buf_b_q[k] <= '0;
            end
            relu_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            buf_c_q <= in_C;
            buf_b_q <= in_bias;
            relu_q  <= relu_en;
        end
    end

    assign out_data   = data_q;
    assign out_idx    = idx_q;
    assign out_valid  = valid_q;
    assign out_last   = last_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = fdone_q;
    assign max_idx    = max_idx_q;
    assign max_val    = max_val_q;
    assign overrun    = overrun_q;

endmodule
